// File: rtl/dac_driver_pkg.sv
// Shared constants and types for the DAC driver: GPIO bus field layout,
// output lane geometry, FIFO depth and the LUT loader byte phase.
package dac_driver_pkg;

  localparam int ADDR_LSB   = 0;
  localparam int DATA_LSB   = 16;
  localparam int WCLK_BIT   = 24;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;

  localparam int LANE_W     = 16;
  localparam int NUM_LANES  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LUT_DEPTH  = 256;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } byte_phase_e;

endpackage

// File: rtl/dac_out_fifo.sv
// Small synchronous FIFO of 16-bit DAC codes. A push while full is accepted
// only when a pop happens in the same cycle.
module dac_out_fifo
  import dac_driver_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [LANE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [LANE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LANE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dac_driver.sv
// Maps 8-bit signed samples through a GPIO-loaded 256x16 LUT onto an AXI-Stream
// DAC lane. Define DAC_DRIVER_IDLE_EN to emit zero idle beats when the FIFO is empty.
module dac_driver
  import dac_driver_pkg::*;
#(
  parameter int CTRL_ADDR   = 3,
  parameter int LUT_ADDR    = 4,
  parameter int SAMPLE_LANE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 gpio_in,
  input  logic [7:0]                  val_in,
  input  logic                        val_valid,
  output logic [LANE_W*NUM_LANES-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        overflow
);

  logic [ADDR_W-1:0] gpio_addr;
  logic [DATA_W-1:0] gpio_data;
  logic              unused_gpio_bits;

  assign gpio_addr        = gpio_in[ADDR_LSB +: ADDR_W];
  assign gpio_data        = gpio_in[DATA_LSB +: DATA_W];
  assign unused_gpio_bits = ^gpio_in[31:WCLK_BIT+1];

  // w_clk comes from another domain; the third flop is for edge detection.
  logic sync1_q, sync2_q, sync3_q;
  logic wr_rise, ctrl_wr, lut_wr, lut_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= gpio_in[WCLK_BIT];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign wr_rise = sync2_q && !sync3_q;
  assign ctrl_wr = wr_rise && (gpio_addr == ADDR_W'(CTRL_ADDR));
  assign lut_wr  = wr_rise && (gpio_addr == ADDR_W'(LUT_ADDR));

  byte_phase_e       phase_q;
  logic [7:0]        ptr_q;
  logic [DATA_W-1:0] low_byte_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= LOW;
      ptr_q      <= '0;
      low_byte_q <= '0;
    end else if (ctrl_wr && gpio_data[0]) begin
      phase_q <= LOW;
      ptr_q   <= '0;
    end else if (lut_wr) begin
      case (phase_q)
        LOW: begin
          low_byte_q <= gpio_data;
          phase_q    <= HIGH;
        end
        HIGH: begin
          ptr_q   <= ptr_q + 8'd1;
          phase_q <= LOW;
        end
        default: phase_q <= LOW;
      endcase
    end
  end

  assign lut_we = lut_wr && (phase_q == HIGH) && !(ctrl_wr && gpio_data[0]);

  // LUT is deliberately left unreset; contents are only meaningful once loaded.
  logic [LANE_W-1:0] lut_q [LUT_DEPTH];
  logic [LANE_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (lut_we)    lut_q[ptr_q] <= {gpio_data, low_byte_q};
    if (val_valid) rd_data_q    <= lut_q[val_in];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_valid_q <= 1'b0;
    else      rd_valid_q <= val_valid;
  end

  logic [LANE_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push, drop;

  assign fifo_pop  = !fifo_empty && m_axis_tready;
  assign drop      = rd_valid_q && fifo_full && !fifo_pop;
  assign fifo_push = rd_valid_q && !drop;

  dac_out_fifo u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push),
    .push_data_i (rd_data_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  logic overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         overflow_q <= 1'b0;
    else if (drop)                    overflow_q <= 1'b1;
    else if (ctrl_wr && gpio_data[1]) overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;

  logic [LANE_W*NUM_LANES-1:0] beat_data;

  always_comb begin
    beat_data = '0;
    if (!fifo_empty) beat_data[LANE_W*SAMPLE_LANE +: LANE_W] = fifo_head;
  end

  assign m_axis_tdata = beat_data;

`ifdef DAC_DRIVER_IDLE_EN
  logic alive_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive_q <= 1'b0;
    else      alive_q <= 1'b1;
  end

  assign m_axis_tvalid = alive_q || !fifo_empty;
`else
  assign m_axis_tvalid = !fifo_empty;
`endif

endmodule

// File: tb/tb_dac_driver.sv
// Directed bench for dac_driver: LUT load, table lookups, sweep, back-pressure,
// full-with-pop, pointer wrap and reset during a partial LUT entry.
module tb_dac_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  gpio_in;
  logic [7:0]   val_in;
  logic         val_valid;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

`ifdef DAC_DRIVER_IDLE_EN
  localparam logic IDLE_VALID = 1'b1;
`else
  localparam logic IDLE_VALID = 1'b0;
`endif

  typedef struct {
    logic [7:0]  val;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[8];

  dac_driver #(
    .CTRL_ADDR   (3),
    .LUT_ADDR    (4),
    .SAMPLE_LANE (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_in       (gpio_in),
    .val_in        (val_in),
    .val_valid     (val_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat(input logic [15:0] code);
    logic [127:0] b;
    b = '0;
    b[79:64] = code;
    return b;
  endfunction

  function automatic logic [15:0] ramp_code(input int k);
    int s;
    s = (k < 128) ? k : k - 256;
    return 16'(s * 8);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gpio_write(input logic [15:0] addr, input logic [7:0] data);
    step();
    gpio_in = {7'($urandom_range(0, 127)), 1'b0, data, addr};
    repeat (2) step();
    gpio_in[24] = 1'b1;
    repeat (4) step();
    gpio_in[24] = 1'b0;
    repeat (3) step();
  endtask

  task automatic load_lut_entry(input logic [15:0] code);
    gpio_write(16'd4, code[7:0]);
    gpio_write(16'd4, code[15:8]);
  endtask

  task automatic load_ramp();
    gpio_write(16'd3, 8'h01);
    for (int k = 0; k < 256; k++) load_lut_entry(ramp_code(k));
  endtask

  // Single lookup on an empty FIFO with tready high; checks the N+2 latency.
  task automatic lookup(input logic [7:0] v, input logic [15:0] code, input string name);
    step();
    val_in    = v;
    val_valid = 1'b1;
    step();
    val_valid = 1'b0;
    check({name, "_early_valid"}, 128'(m_axis_tvalid), 128'(IDLE_VALID));
    step();
    check({name, "_valid"}, 128'(m_axis_tvalid), 128'(1'b1));
    check({name, "_data"}, m_axis_tdata, beat(code));
    step();
    check({name, "_after_valid"}, 128'(m_axis_tvalid), 128'(IDLE_VALID));
  endtask

  task automatic drain_expected(input string name);
    m_axis_tready = 1'b1;
    while (exp_q.size() > 0) begin
      check({name, "_valid"}, 128'(m_axis_tvalid), 128'(1'b1));
      check({name, "_data"}, m_axis_tdata, beat(exp_q.pop_front()));
      step();
    end
    check({name, "_empty_valid"}, 128'(m_axis_tvalid), 128'(IDLE_VALID));
    check({name, "_empty_data"}, m_axis_tdata, 128'(0));
  endtask

  initial begin
    vecs[0] = '{8'h05, 16'h0028};
    vecs[1] = '{8'h80, 16'hFC00};
    vecs[2] = '{8'h00, 16'h0000};
    vecs[3] = '{8'h7F, 16'h03F8};
    vecs[4] = '{8'hFF, 16'hFFF8};
    vecs[5] = '{8'h01, 16'h0008};
    vecs[6] = '{8'h81, 16'hFC08};
    vecs[7] = '{8'h40, 16'h0200};

    rst           = 1'b0;
    gpio_in       = '0;
    val_in        = '0;
    val_valid     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    check("reset_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
    check("reset_tdata", m_axis_tdata, 128'(0));
    check("reset_overflow", 128'(overflow), 128'(1'b0));
    rst = 1'b1;
    step();
    check("post_reset_tvalid", 128'(m_axis_tvalid), 128'(IDLE_VALID));
    check("post_reset_tdata", m_axis_tdata, 128'(0));

    load_ramp();
    for (int i = 0; i < 8; i++) lookup(vecs[i].val, vecs[i].code, $sformatf("vec%0d", i));

    // Sweep: one strobe per cycle, each beat due two cycles later.
    m_axis_tready = 1'b1;
    for (int c = 0; c < 258; c++) begin
      step();
      if (c >= 2) begin
        check("sweep_valid", 128'(m_axis_tvalid), 128'(1'b1));
        check("sweep_data", m_axis_tdata, beat(ramp_code(c - 2)));
      end
      if (c < 256) begin
        val_in    = 8'(c);
        val_valid = 1'b1;
      end else begin
        val_valid = 1'b0;
      end
    end
    step();
    check("sweep_overflow", 128'(overflow), 128'(1'b0));
    check("sweep_end_valid", 128'(m_axis_tvalid), 128'(IDLE_VALID));

    // Back-pressure: six strobes into a four-deep FIFO.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      val_in    = 8'(i + 1);
      val_valid = 1'b1;
      if (i < 4) exp_q.push_back(ramp_code(i + 1));
    end
    step();
    val_valid = 1'b0;
    repeat (2) step();
    check("bp_overflow_set", 128'(overflow), 128'(1'b1));
    check("bp_hold_valid", 128'(m_axis_tvalid), 128'(1'b1));
    check("bp_hold_data", m_axis_tdata, beat(16'h0008));
    step();
    check("bp_stable_data", m_axis_tdata, beat(16'h0008));
    drain_expected("bp");
    gpio_write(16'd3, 8'h02);
    check("bp_overflow_clear", 128'(overflow), 128'(1'b0));

    // Full FIFO: the push lands in the same cycle as a pop.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      val_in    = 8'(8'h10 + i);
      val_valid = 1'b1;
    end
    step();
    val_valid = 1'b0;
    repeat (2) step();
    check("full_no_overflow", 128'(overflow), 128'(1'b0));
    val_in    = 8'h20;
    val_valid = 1'b1;
    step();
    val_valid     = 1'b0;
    m_axis_tready = 1'b1;
    check("full_pop_data", m_axis_tdata, beat(16'h0080));
    step();
    m_axis_tready = 1'b0;
    check("full_pop_overflow", 128'(overflow), 128'(1'b0));
    exp_q.push_back(16'h0088);
    exp_q.push_back(16'h0090);
    exp_q.push_back(16'h0098);
    exp_q.push_back(16'h0100);
    drain_expected("fullpop");
    check("fullpop_end_overflow", 128'(overflow), 128'(1'b0));

    // Pointer wrap: the 257th entry overwrites entry 0 only.
    gpio_write(16'd3, 8'h01);
    for (int k = 0; k < 256; k++) load_lut_entry(ramp_code(k));
    load_lut_entry(16'hBEEF);
    lookup(8'h00, 16'hBEEF, "wrap_e0");
    lookup(8'h01, 16'h0008, "wrap_e1");

    // Reset mid-operation with a queued beat and a half-written entry.
    gpio_write(16'd4, 8'h55);
    m_axis_tready = 1'b0;
    step();
    val_in    = 8'h02;
    val_valid = 1'b1;
    step();
    val_valid = 1'b0;
    repeat (2) step();
    check("mid_queued_valid", 128'(m_axis_tvalid), 128'(1'b1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid_reset_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
    check("mid_reset_tdata", m_axis_tdata, 128'(0));
    repeat (2) step();
    rst           = 1'b1;
    m_axis_tready = 1'b1;
    step();
    check("mid_release_tvalid", 128'(m_axis_tvalid), 128'(IDLE_VALID));
    check("mid_release_tdata", m_axis_tdata, 128'(0));
    gpio_write(16'd4, 8'h34);
    gpio_write(16'd9, 8'h99);
    gpio_write(16'd4, 8'h12);
    lookup(8'h00, 16'h1234, "rst_e0");
    lookup(8'h01, 16'h0008, "rst_e1");
    check("final_overflow", 128'(overflow), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
